// File: rtl/sample_frame_scheduler.sv
// Captures DEPTH samples at a programmable sample period into a frame buffer,
// then drains the frame over a valid/ready stream before capturing the next.
module sample_frame_scheduler #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [2:0]       rate_sel,
    input  logic [WIDTH-1:0] sample_in,
    output logic             sample_strobe,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic [7:0]       overrun_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [7:0]       div_q, div_d;
    logic [2:0]       rate_q, rate_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [7:0]       ovr_q, ovr_d;
    logic             buf_we;
    logic [7:0]       period_m1;
    logic [WIDTH-1:0] buffer_mem [DEPTH];

    // P-1 for P = 2^(rate+1): a right-shifted all-ones mask, 1..255.
    assign period_m1     = 8'hFF >> (3'd7 - rate_q);
    assign sample_strobe = (state_q != ST_IDLE) && (div_q == period_m1);
    assign busy          = (state_q != ST_IDLE);
    assign out_valid     = (state_q == ST_DRAIN);
    assign out_last      = out_valid && (rd_ptr_q == PTR_LAST);
    assign out_data      = out_valid ? buffer_mem[rd_ptr_q] : '0;
    assign overrun_cnt   = ovr_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        div_d    = div_q;
        rate_d   = rate_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovr_d    = ovr_q;
        buf_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                div_d = 8'd0;
                if (enable) begin
                    state_d  = ST_CAPTURE;
                    rate_d   = rate_sel;
                    wr_ptr_d = '0;
                end
            end

            ST_CAPTURE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    div_d   = 8'd0;
                end else begin
                    div_d = sample_strobe ? 8'd0 : 8'(div_q + 8'd1);
                    if (sample_strobe) begin
                        buf_we   = 1'b1;
                        wr_ptr_d = AW'(wr_ptr_q + 1'b1);
                        if (wr_ptr_q == PTR_LAST) begin
                            state_d  = ST_DRAIN;
                            rd_ptr_d = '0;
                        end
                    end
                end
            end

            ST_DRAIN: begin
                div_d = sample_strobe ? 8'd0 : 8'(div_q + 8'd1);
                if (sample_strobe && (ovr_q != 8'hFF)) begin
                    ovr_d = 8'(ovr_q + 8'd1);
                end
                if (out_ready) begin
                    rd_ptr_d = AW'(rd_ptr_q + 1'b1);
                    // Drain always completes; enable only decides what follows it.
                    if (rd_ptr_q == PTR_LAST) begin
                        div_d = 8'd0;
                        if (enable) begin
                            state_d  = ST_CAPTURE;
                            rate_d   = rate_sel;
                            wr_ptr_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                div_d   = 8'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            div_q    <= 8'd0;
            rate_q   <= 3'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovr_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            rate_q   <= rate_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovr_q    <= ovr_d;
        end
    end

    // NOTE: the frame memory is deliberately not reset; out_data is masked outside DRAIN.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            buffer_mem[wr_ptr_q] <= sample_in;
        end
    end

endmodule

// File: tb/tb_sample_frame_scheduler.sv
// Self-checking bench: randomized and directed stimulus compared every cycle
// against a frame-level reference model (queue of captured samples).
module tb_sample_frame_scheduler;

    localparam int WIDTH = 12;
    localparam int DEPTH = 16;

    logic             clock;
    logic             reset_n;
    logic             enable;
    logic [2:0]       rate_sel;
    logic [WIDTH-1:0] sample_in;
    logic             sample_strobe;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic [7:0]       overrun_cnt;

    sample_frame_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .rate_sel      (rate_sel),
        .sample_in     (sample_in),
        .sample_strobe (sample_strobe),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .busy          (busy),
        .overrun_cnt   (overrun_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef enum int {M_IDLE, M_CAP, M_DRAIN} mode_e;

    mode_e            m_mode;
    int               m_t;
    int               m_p;
    int               m_ovr;
    logic [WIDTH-1:0] m_frame [$];

    int               n_checks;
    int               n_errors;
    int               cyc;
    bit               use_index;
    bit               valid_seen;
    int               drain_strobes;
    logic [WIDTH-1:0] xfer_q [$];
    logic             last_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic m_strobe();
        return (m_mode != M_IDLE) && ((m_t % m_p) == m_p - 1);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_t    = 0;
        m_p    = 2;
        m_ovr  = 0;
        m_frame.delete();
    endtask

    task automatic model_step(input logic en, input logic [2:0] rs, input logic rdy,
                              input logic [WIDTH-1:0] sin);
        logic stb;
        stb = m_strobe();
        case (m_mode)
            M_IDLE: begin
                if (en) begin
                    m_mode = M_CAP;
                    m_p    = 2 << rs;
                    m_t    = 0;
                    m_frame.delete();
                end
            end
            M_CAP: begin
                if (!en) begin
                    m_mode = M_IDLE;
                end else begin
                    if (stb) m_frame.push_back(sin);
                    m_t++;
                    if (m_frame.size() == DEPTH) m_mode = M_DRAIN;
                end
            end
            M_DRAIN: begin
                if (stb && m_ovr < 255) m_ovr++;
                m_t++;
                if (rdy) begin
                    void'(m_frame.pop_front());
                    if (m_frame.size() == 0) begin
                        if (en) begin
                            m_mode = M_CAP;
                            m_p    = 2 << rs;
                            m_t    = 0;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic compare_all();
        check("strobe",  sample_strobe, m_strobe());
        check("valid",   out_valid, m_mode == M_DRAIN);
        check("last",    out_last, (m_mode == M_DRAIN) && (m_frame.size() == 1));
        check("data",    out_data, (m_mode == M_DRAIN) ? m_frame[0] : '0);
        check("busy",    busy, m_mode != M_IDLE);
        check("overrun", overrun_cnt, m_ovr);
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model across the
    // rising edge, and compare at the next falling edge.
    task automatic run_cycle(input logic en, input logic [2:0] rs, input logic rdy);
        logic [WIDTH-1:0] sin;
        sin = use_index ? WIDTH'(cyc) : WIDTH'($urandom);
        if (out_valid && rdy) begin
            xfer_q.push_back(out_data);
            last_q.push_back(out_last);
        end
        if (out_valid) valid_seen = 1'b1;
        if (out_valid && sample_strobe) drain_strobes++;
        enable    = en;
        rate_sel  = rs;
        out_ready = rdy;
        sample_in = sin;
        model_step(en, rs, rdy, sin);
        @(negedge clock);
        cyc++;
        compare_all();
    endtask

    task automatic to_idle(input string tag);
        int n;
        n = 0;
        while (m_mode != M_IDLE && n < 600) begin
            run_cycle(1'b0, 3'($urandom), 1'b1);
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic wait_drain(input string tag, input logic [2:0] rs);
        int n;
        n = 0;
        while (m_mode != M_DRAIN && n < 400) begin
            run_cycle(1'b1, rs, 1'b1);
            n++;
        end
        check(tag, out_valid, 1'b1);
    endtask

    task automatic wait_xfers(input int cnt, input logic [2:0] rs);
        int n;
        n = 0;
        while (xfer_q.size() < cnt && n < 400) begin
            run_cycle(1'b1, rs, 1'b1);
            n++;
        end
    endtask

    task automatic check_frame_order(input string tag, input int step);
        check({tag, "_count"}, xfer_q.size(), DEPTH);
        if (xfer_q.size() >= DEPTH) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                check({tag, "_step"}, WIDTH'(xfer_q[i+1] - xfer_q[i]), step);
                check({tag, "_notlast"}, last_q[i], 1'b0);
            end
            check({tag, "_last"}, last_q[DEPTH-1], 1'b1);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int               n;
        int               ovr_start;
        logic [WIDTH-1:0] held;

        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        use_index = 1'b0;
        valid_seen = 1'b0;
        drain_strobes = 0;
        reset_n   = 1'b0;
        enable    = 1'b0;
        rate_sel  = 3'd0;
        out_ready = 1'b0;
        sample_in = '0;
        model_reset();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        compare_all();

        // Rate 0, index samples, always ready: 16 samples two clocks apart, last on 16th.
        use_index = 1'b1;
        xfer_q.delete();
        last_q.delete();
        wait_xfers(DEPTH, 3'd0);
        check_frame_order("a", 2);
        to_idle("a_idle");

        // Rate 7: first strobe 256 clocks after entry, then every 256 clocks.
        use_index = 1'b0;
        run_cycle(1'b1, 3'd7, 1'b1);
        n = 0;
        while (!sample_strobe && n < 400) begin
            run_cycle(1'b1, 3'($urandom), 1'b1);
            n++;
        end
        check("b_first", n + 1, 256);
        n = 0;
        do begin
            run_cycle(1'b1, 3'($urandom), 1'b1);
            n++;
        end while (!sample_strobe && n < 400);
        check("b_space", n, 256);
        to_idle("b_idle");

        // Backpressure mid-drain: data held, nothing lost, overrun counts drain strobes.
        use_index = 1'b1;
        xfer_q.delete();
        last_q.delete();
        wait_drain("c_drain", 3'd0);
        ovr_start     = overrun_cnt;
        drain_strobes = 0;
        repeat (4) run_cycle(1'b1, 3'd0, 1'b1);
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            run_cycle(1'b1, 3'd0, 1'b0);
            check("c_hold", out_data, held);
        end
        wait_xfers(DEPTH, 3'd0);
        check_frame_order("c", 2);
        check("c_ovr", overrun_cnt - ovr_start, drain_strobes);
        to_idle("c_idle");

        // Enable dropped after 5 captures: abort on that edge, no output ever.
        valid_seen = 1'b0;
        n = 0;
        while (m_frame.size() < 5 && n < 50) begin
            run_cycle(1'b1, 3'd0, 1'b1);
            n++;
        end
        run_cycle(1'b0, 3'd0, 1'b1);
        check("d_abort", busy, 1'b0);
        repeat (8) run_cycle(1'b0, 3'($urandom), 1'b1);
        check("d_novalid", valid_seen, 1'b0);

        // Enable dropped mid-drain: the whole frame still drains, then IDLE.
        xfer_q.delete();
        last_q.delete();
        wait_drain("d_drain", 3'd0);
        n = 0;
        while (m_mode != M_IDLE && n < 400) begin
            run_cycle(1'b0, 3'd0, 1'($urandom));
            n++;
        end
        check("d_full_drain", xfer_q.size(), DEPTH);
        check("d_idle", busy, 1'b0);

        // rate_sel 0 -> 2 mid-capture: this frame keeps period 2, next frame uses 8.
        xfer_q.delete();
        last_q.delete();
        repeat (10) run_cycle(1'b1, 3'd0, 1'b1);
        wait_xfers(DEPTH, 3'd2);
        check_frame_order("e", 2);
        n = 0;
        while (!sample_strobe && n < 100) begin
            run_cycle(1'b1, 3'd2, 1'b1);
            n++;
        end
        n = 0;
        do begin
            run_cycle(1'b1, 3'd2, 1'b1);
            n++;
        end while (!sample_strobe && n < 100);
        check("e_space", n, 8);
        to_idle("e_idle");

        // Randomized traffic, checked cycle by cycle against the model.
        use_index = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            run_cycle($urandom_range(0, 63) != 0, 3'($urandom_range(0, 3)),
                      $urandom_range(0, 3) != 0);
        end
        to_idle("r_idle");

        // Long stall saturates overrun_cnt, then an asynchronous reset mid-drain.
        wait_drain("g_drain", 3'd0);
        repeat (2) run_cycle(1'b1, 3'd0, 1'b1);
        repeat (600) run_cycle(1'b1, 3'd0, 1'b0);
        check("g_sat", overrun_cnt, 255);
        #2;
        reset_n = 1'b0;
        #1;
        check("g_rst_strobe", sample_strobe, 1'b0);
        check("g_rst_valid",  out_valid, 1'b0);
        check("g_rst_last",   out_last, 1'b0);
        check("g_rst_busy",   busy, 1'b0);
        check("g_rst_data",   out_data, '0);
        check("g_rst_ovr",    overrun_cnt, 0);
        model_reset();
        enable = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        compare_all();
        repeat (60) run_cycle(1'b1, 3'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
